// File: rtl/tick_pkg.sv
// Shared types and default constants for the tick scheduler.
// No logic; compile-time only.
// No flow control.
package tick_pkg;

   typedef enum logic {
      ST_PAUSED  = 1'b0,
      ST_RUNNING = 1'b1
   } state_t;

   localparam int RATE_W    = 2;
   localparam int CNT_W_DEF = 27;
   localparam int DIV0_DEF  = 100_000_000;
   localparam int DIV1_DEF  = 50_000_000;
   localparam int DIV2_DEF  = 25_000_000;
   localparam int DIV3_DEF  = 12_500_000;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector on an already-synchronized level.
// Latency: combinational pulse in the cycle the level first reads high.
// No backpressure; the prev register resets high so a held input never fires.
module edge_detect (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_level,
   output logic o_rise
);

   logic r_prev;

   // Remember last cycle's level; reset high to mask buttons held through reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_prev <= 1'b1;
      end else begin
         r_prev <= i_level;
      end
   end

   assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/tick_controller.sv
// Run/pause/single-step tick scheduler with four selectable divide rates.
// Latency: step tick 1 cycle after the step edge; first run tick DIV cycles after the run edge.
// No backpressure; tick is a one-cycle enable and out_clk toggles on every tick.
module tick_controller
   import tick_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int DIV0  = DIV0_DEF,
   parameter int DIV1  = DIV1_DEF,
   parameter int DIV2  = DIV2_DEF,
   parameter int DIV3  = DIV3_DEF
) (
   input  logic              in_clk,
   input  logic              reset,
   input  logic              run_btn,
   input  logic              step_btn,
   input  logic [RATE_W-1:0] rate_sel,
   output logic              tick,
   output logic              out_clk,
   output logic              running,
   output logic [RATE_W-1:0] rate_active
);

   localparam logic [CNT_W-1:0] L_DIV0_M1 = CNT_W'(DIV0 - 1);
   localparam logic [CNT_W-1:0] L_DIV1_M1 = CNT_W'(DIV1 - 1);
   localparam logic [CNT_W-1:0] L_DIV2_M1 = CNT_W'(DIV2 - 1);
   localparam logic [CNT_W-1:0] L_DIV3_M1 = CNT_W'(DIV3 - 1);

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_tick;
   logic                r_out_clk;
   logic [RATE_W-1:0]   r_rate;

   state_t              w_state_nxt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic                w_tick_nxt;
   logic                w_out_clk_nxt;
   logic [RATE_W-1:0]   w_rate_nxt;
   logic [CNT_W-1:0]    w_div_m1;
   logic                w_run_rise;
   logic                w_step_rise;

   edge_detect u_run_edge (
      .i_clk   (in_clk),
      .i_reset (reset),
      .i_level (run_btn),
      .o_rise  (w_run_rise)
   );

   edge_detect u_step_edge (
      .i_clk   (in_clk),
      .i_reset (reset),
      .i_level (step_btn),
      .o_rise  (w_step_rise)
   );

   // Terminal count for the rate currently applied to the counter.
   always_comb begin
      w_div_m1 = L_DIV0_M1;
      case (r_rate)
         2'd0:    w_div_m1 = L_DIV0_M1;
         2'd1:    w_div_m1 = L_DIV1_M1;
         2'd2:    w_div_m1 = L_DIV2_M1;
         default: w_div_m1 = L_DIV3_M1;
      endcase
   end

   // Next state, counter, tick and rate; run edges take priority over step edges.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = '0;
      w_tick_nxt    = 1'b0;
      w_out_clk_nxt = r_out_clk;
      w_rate_nxt    = r_rate;
      case (r_state)
         ST_PAUSED: begin
            // Rate tracks the switches freely while nothing is counting.
            w_rate_nxt = rate_sel;
            if (w_run_rise) begin
               w_state_nxt = ST_RUNNING;
            end else if (w_step_rise) begin
               w_tick_nxt    = 1'b1;
               w_out_clk_nxt = ~r_out_clk;
            end
         end
         default: begin
            if (w_run_rise) begin
               // Pausing wins over a wrap landing in the same cycle.
               w_state_nxt = ST_PAUSED;
            end else if (r_cnt == w_div_m1) begin
               // Rate only changes at a tick boundary so no period is cut short or stretched.
               w_tick_nxt    = 1'b1;
               w_out_clk_nxt = ~r_out_clk;
               w_rate_nxt    = rate_sel;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
      endcase
   end

   // State and output registers with synchronous clear.
   always_ff @(posedge in_clk) begin
      if (reset) begin
         r_state   <= ST_PAUSED;
         r_cnt     <= '0;
         r_tick    <= 1'b0;
         r_out_clk <= 1'b0;
         r_rate    <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_tick    <= w_tick_nxt;
         r_out_clk <= w_out_clk_nxt;
         r_rate    <= w_rate_nxt;
      end
   end

   assign tick        = r_tick;
   assign out_clk     = r_out_clk;
   assign running     = (r_state == ST_RUNNING);
   assign rate_active = r_rate;

endmodule

// File: tb/tb_tick_controller.sv
// Bench for tick_controller with DIV0..3 = 8,4,2,1 and a 4-bit counter.
// Expected tick cycles are queued when stimulus is driven and popped as ticks appear.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_tick_controller;

   logic       in_clk;
   logic       reset;
   logic       run_btn;
   logic       step_btn;
   logic [1:0] rate_sel;
   logic       tick;
   logic       out_clk;
   logic       running;
   logic [1:0] rate_active;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   int exp_q[$];
   int e0;
   int e1;
   logic exp_oc;

   tick_controller #(
      .CNT_W (4),
      .DIV0  (8),
      .DIV1  (4),
      .DIV2  (2),
      .DIV3  (1)
   ) dut (
      .in_clk      (in_clk),
      .reset       (reset),
      .run_btn     (run_btn),
      .step_btn    (step_btn),
      .rate_sel    (rate_sel),
      .tick        (tick),
      .out_clk     (out_clk),
      .running     (running),
      .rate_active (rate_active)
   );

   initial in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   // Posedge counter: after the k-th rising edge, cyc == k.
   always @(posedge in_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d expected=%0d (cyc %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge in_clk);
   endtask

   // Scoreboard: every observed tick must match the oldest queued expected cycle.
   always @(negedge in_clk) begin
      if (tick === 1'b1) begin
         if (exp_q.size() == 0) chk("tick_extra", 32'(tick), 0);
         else                   chk("tick_cyc", cyc, exp_q.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b1;
      run_btn  = 1'b1;
      step_btn = 1'b0;
      rate_sel = 2'd0;
      @(negedge in_clk);
      @(negedge in_clk);
      chk("rst_running", 32'(running), 0);
      chk("rst_out_clk", 32'(out_clk), 0);
      chk("rst_rate",    32'(rate_active), 0);
      chk("rst_tick",    32'(tick), 0);

      // Run button held through reset release must not start the scheduler.
      reset = 1'b0;
      wait_until(cyc + 6);
      chk("hold_running", 32'(running), 0);
      chk("hold_out_clk", 32'(out_clk), 0);

      // Run at rate 1 (DIV 4): ticks after E0+4, +8, +12.
      rate_sel = 2'd1;
      run_btn  = 1'b0;
      @(negedge in_clk);
      run_btn = 1'b1;
      e0 = cyc + 1;
      exp_q.push_back(e0 + 4);
      exp_q.push_back(e0 + 8);
      exp_q.push_back(e0 + 12);
      @(negedge in_clk);
      chk("run_running", 32'(running), 1);
      chk("run_rate",    32'(rate_active), 1);
      run_btn = 1'b0;
      wait_until(e0 + 3);
      chk("r1_oc_pre", 32'(out_clk), 0);
      wait_until(e0 + 4);
      chk("r1_oc_1", 32'(out_clk), 1);
      wait_until(e0 + 8);
      chk("r1_oc_2", 32'(out_clk), 0);
      wait_until(e0 + 12);
      chk("r1_oc_3", 32'(out_clk), 1);
      @(negedge in_clk);
      run_btn = 1'b1;
      @(negedge in_clk);
      chk("r1_pause_running", 32'(running), 0);
      run_btn = 1'b0;
      repeat (4) @(negedge in_clk);
      chk("r1_q_empty", exp_q.size(), 0);

      // Paused stepping: three steps 5 cycles apart.
      exp_oc = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step_btn = 1'b1;
         exp_q.push_back(cyc + 1);
         @(negedge in_clk);
         exp_oc = ~exp_oc;
         chk("step_oc", 32'(out_clk), 32'(exp_oc));
         chk("step_running", 32'(running), 0);
         step_btn = 1'b0;
         repeat (4) @(negedge in_clk);
      end
      chk("step_q_empty", exp_q.size(), 0);

      // Rate switch mid-period: rate 0 period completes, then rate 2.
      rate_sel = 2'd0;
      @(negedge in_clk);
      run_btn = 1'b1;
      e0 = cyc + 1;
      exp_q.push_back(e0 + 8);
      exp_q.push_back(e0 + 10);
      exp_q.push_back(e0 + 12);
      exp_q.push_back(e0 + 14);
      @(negedge in_clk);
      run_btn = 1'b0;
      wait_until(e0 + 3);
      rate_sel = 2'd2;
      wait_until(e0 + 7);
      chk("sw_rate_old", 32'(rate_active), 0);
      wait_until(e0 + 8);
      chk("sw_rate_new", 32'(rate_active), 2);
      chk("sw_oc", 32'(out_clk), 1);
      wait_until(e0 + 14);
      run_btn = 1'b1;
      @(negedge in_clk);
      chk("sw_pause_running", 32'(running), 0);
      chk("sw_pause_oc", 32'(out_clk), 0);
      run_btn = 1'b0;
      repeat (3) @(negedge in_clk);
      chk("sw_q_empty", exp_q.size(), 0);

      // Simultaneous run and step edges: run wins, then DIV 1 ticks every cycle.
      rate_sel = 2'd3;
      @(negedge in_clk);
      run_btn  = 1'b1;
      step_btn = 1'b1;
      e0 = cyc + 1;
      for (int k = 1; k <= 5; k++) exp_q.push_back(e0 + k);
      @(negedge in_clk);
      chk("sim_running", 32'(running), 1);
      chk("sim_no_step", 32'(out_clk), 0);
      run_btn  = 1'b0;
      step_btn = 1'b0;
      wait_until(e0 + 5);
      run_btn = 1'b1;
      @(negedge in_clk);
      chk("sim_pause_running", 32'(running), 0);
      chk("sim_oc", 32'(out_clk), 1);
      run_btn = 1'b0;
      repeat (3) @(negedge in_clk);
      chk("sim_q_empty", exp_q.size(), 0);

      // Pause exactly in the wrap cycle, then restart and reset mid-period.
      rate_sel = 2'd1;
      @(negedge in_clk);
      run_btn = 1'b1;
      e0 = cyc + 1;
      exp_q.push_back(e0 + 4);
      @(negedge in_clk);
      run_btn = 1'b0;
      wait_until(e0 + 7);
      run_btn = 1'b1;
      @(negedge in_clk);
      chk("wrap_pause_running", 32'(running), 0);
      chk("wrap_pause_tick",    32'(tick), 0);
      chk("wrap_pause_oc",      32'(out_clk), 0);
      run_btn = 1'b0;
      @(negedge in_clk);
      run_btn = 1'b1;
      e1 = cyc + 1;
      exp_q.push_back(e1 + 4);
      wait_until(e1 + 5);
      chk("rr_running", 32'(running), 1);
      chk("rr_oc",      32'(out_clk), 1);
      reset = 1'b1;
      @(negedge in_clk);
      chk("mid_rst_running", 32'(running), 0);
      chk("mid_rst_oc",      32'(out_clk), 0);
      chk("mid_rst_rate",    32'(rate_active), 0);
      chk("mid_rst_tick",    32'(tick), 0);
      reset = 1'b0;
      repeat (4) @(negedge in_clk);
      chk("post_rst_running", 32'(running), 0);
      chk("final_q_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
